// File: rtl/regfile_port_sched_pkg.sv
// ----------------------------------------------------------------------------
// regfile_port_sched_pkg
// Shared constants and helpers for the register-file port scheduler.
//   REQ_ALU / REQ_MEM : index of each write requester in the arbiter vectors
//   onehot_decode     : register address -> one-hot strobe vector. The result
//                       is sized for the largest supported file; callers
//                       narrow it to NREGS bits with a size cast.
// ----------------------------------------------------------------------------
package regfile_port_sched_pkg;

  localparam int REQ_ALU   = 0;
  localparam int REQ_MEM   = 1;

  localparam int MAX_NREGS = 16;
  localparam int MAX_AW    = 4;

  function automatic logic [MAX_NREGS-1:0] onehot_decode(input logic [MAX_AW-1:0] addr);
    logic [MAX_NREGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_port_sched_arb.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a 1-bit priority pointer.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, pointer returns to requester 0
//   valid   : request vector, bit n = requester n
//   grant   : one-hot (or zero) grant, combinational from valid and pointer
// A lone requester always wins. Under contention the pointer names the
// winner and then flips, so the pointer only moves when both request.
// ----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic r_ptr;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= 1'b0;
    end else if (valid == 2'b11) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule

// File: rtl/regfile_port_sched.sv
// ----------------------------------------------------------------------------
// regfile_port_sched
// Sequences writes and reads of an external bank of NREGS 16-bit registers.
//   clock, reset_n                  : clock, asynchronous active-low reset
//   wr0_valid/addr/data, wr0_ready  : write requester 0 (ALU writeback)
//   wr1_valid/addr/data, wr1_ready  : write requester 1 (memory load)
//   rd_valid/addr_a/addr_b, rd_ready: read request for buses A and B
//   load, d_in                      : per-register load strobes, write data
//   oe_a, oe_b                      : per-register output enables, buses A/B
// Handshake: a request transfers in the cycle where its valid and ready are
// both high; ready never depends on anything but valids, the arbiter
// pointer and reset. Every transfer shows up on the registered strobes in
// the following cycle only, so the register bank sees a write two cycles
// after the handshake and a same-cycle read observes the old contents.
// ----------------------------------------------------------------------------
module regfile_port_sched
  import regfile_port_sched_pkg::*;
#(
  parameter  int NREGS   = 8,
  parameter  bit R0_ZERO = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr0_valid,
  input  logic [AW-1:0]    wr0_addr,
  input  logic [15:0]      wr0_data,
  output logic             wr0_ready,
  input  logic             wr1_valid,
  input  logic [AW-1:0]    wr1_addr,
  input  logic [15:0]      wr1_data,
  output logic             wr1_ready,
  input  logic             rd_valid,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic             rd_ready,
  output logic [NREGS-1:0] load,
  output logic [15:0]      d_in,
  output logic [NREGS-1:0] oe_a,
  output logic [NREGS-1:0] oe_b
);

  logic [1:0]       w_valid;
  logic [1:0]       w_grant;
  logic             w_wr_fire;
  logic [AW-1:0]    w_wr_addr;
  logic [15:0]      w_wr_data;
  logic             w_wr_drop;
  logic [NREGS-1:0] w_load_nxt;

  logic [NREGS-1:0] r_load;
  logic [15:0]      r_d_in;
  logic [NREGS-1:0] r_oe_a;
  logic [NREGS-1:0] r_oe_b;

  assign w_valid[REQ_ALU] = wr0_valid;
  assign w_valid[REQ_MEM] = wr1_valid;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (w_valid),
    .grant   (w_grant)
  );

  // Readies are forced low during reset; the state flops are held in reset
  // anyway, so the internal fire signal can use the raw grant.
  assign wr0_ready = reset_n & w_grant[REQ_ALU];
  assign wr1_ready = reset_n & w_grant[REQ_MEM];
  assign rd_ready  = reset_n;

  assign w_wr_fire = |w_grant;
  assign w_wr_addr = w_grant[REQ_MEM] ? wr1_addr : wr0_addr;
  assign w_wr_data = w_grant[REQ_MEM] ? wr1_data : wr0_data;

  // A write to register 0 is acknowledged but never strobed when it is
  // hard-wired to zero.
  assign w_wr_drop  = R0_ZERO && (w_wr_addr == '0);
  assign w_load_nxt = (w_wr_fire && !w_wr_drop)
                      ? NREGS'(onehot_decode(MAX_AW'(w_wr_addr))) : '0;

  // Write stage: strobes are single-cycle, data bus holds its last value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_load <= '0;
      r_d_in <= '0;
    end else begin
      r_load <= w_load_nxt;
      if (w_wr_fire) begin
        r_d_in <= w_wr_data;
      end
    end
  end

  // Read stage: always ready, enables asserted for exactly one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_oe_a <= '0;
      r_oe_b <= '0;
    end else if (rd_valid) begin
      r_oe_a <= NREGS'(onehot_decode(MAX_AW'(rd_addr_a)));
      r_oe_b <= NREGS'(onehot_decode(MAX_AW'(rd_addr_b)));
    end else begin
      r_oe_a <= '0;
      r_oe_b <= '0;
    end
  end

  assign load = r_load;
  assign d_in = r_d_in;
  assign oe_a = r_oe_a;
  assign oe_b = r_oe_b;

endmodule

// File: tb/tb_regfile_port_sched.sv
// ----------------------------------------------------------------------------
// tb_regfile_port_sched
// Bench for regfile_port_sched (NREGS=8, R0_ZERO=1). Directed cycles are
// driven on the falling edge; each driven cycle pushes the output values
// expected after the next rising edge. A monitor pops one entry per rising
// edge and compares load, d_in, oe_a, oe_b and, where requested, the value
// bus A would carry from a behavioural register bank fed by load/d_in.
// ----------------------------------------------------------------------------
module tb_regfile_port_sched;

  localparam int NREGS = 8;
  localparam int AW    = 3;

  typedef struct packed {
    logic [7:0]  load;
    logic [15:0] d_in;
    logic [7:0]  oe_a;
    logic [7:0]  oe_b;
    logic        chk_bus;
    logic [15:0] bus;
  } exp_t;

  localparam int W = $bits(exp_t);

  logic          clock;
  logic          reset_n;
  logic          wr0_valid;
  logic [AW-1:0] wr0_addr;
  logic [15:0]   wr0_data;
  logic          wr0_ready;
  logic          wr1_valid;
  logic [AW-1:0] wr1_addr;
  logic [15:0]   wr1_data;
  logic          wr1_ready;
  logic          rd_valid;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          rd_ready;
  logic [7:0]    load;
  logic [15:0]   d_in;
  logic [7:0]    oe_a;
  logic [7:0]    oe_b;

  logic [W-1:0]  exp_q[$];
  logic [15:0]   regs[NREGS];
  logic [15:0]   exp_din;
  int            n_tests;
  int            n_fail;

  regfile_port_sched #(.NREGS(NREGS), .R0_ZERO(1'b1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr0_valid (wr0_valid),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr0_ready (wr0_ready),
    .wr1_valid (wr1_valid),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .wr1_ready (wr1_ready),
    .rd_valid  (rd_valid),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_ready  (rd_ready),
    .load      (load),
    .d_in      (d_in),
    .oe_a      (oe_a),
    .oe_b      (oe_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural register bank driven by the scheduler strobes.
  initial begin
    for (int i = 0; i < NREGS; i++) regs[i] = 16'h0000;
  end
  always @(posedge clock) begin
    for (int i = 0; i < NREGS; i++) begin
      if (load[i] === 1'b1) regs[i] <= d_in;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic rst_cycle();
    exp_t e;
    @(negedge clock);
    reset_n   = 1'b0;
    wr0_valid = 1'b1; wr0_addr = 3'd3; wr0_data = 16'hAAAA;
    wr1_valid = 1'b1; wr1_addr = 3'd5; wr1_data = 16'h5555;
    rd_valid  = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd2;
    #1;
    chk("rst_wr0_ready", 32'(wr0_ready), 32'd0);
    chk("rst_wr1_ready", 32'(wr1_ready), 32'd0);
    chk("rst_rd_ready",  32'(rd_ready),  32'd0);
    exp_din = 16'h0000;
    e = '0;
    exp_q.push_back(W'(e));
  endtask

  // One normal cycle. eg0/eg1 are the hand-derived grants for this cycle;
  // cb/eb request a bus-A value check for the following cycle.
  task automatic drive(input bit w0v, input logic [2:0] w0a, input logic [15:0] w0d,
                       input bit w1v, input logic [2:0] w1a, input logic [15:0] w1d,
                       input bit rv, input logic [2:0] ra, input logic [2:0] rb,
                       input bit eg0, input bit eg1, input bit cb, input logic [15:0] eb);
    exp_t e;
    logic [7:0] one;
    @(negedge clock);
    reset_n   = 1'b1;
    wr0_valid = w0v; wr0_addr = w0a; wr0_data = w0d;
    wr1_valid = w1v; wr1_addr = w1a; wr1_data = w1d;
    rd_valid  = rv;  rd_addr_a = ra; rd_addr_b = rb;
    #1;
    chk("wr0_ready", 32'(wr0_ready), 32'(eg0));
    chk("wr1_ready", 32'(wr1_ready), 32'(eg1));
    chk("rd_ready",  32'(rd_ready),  32'd1);
    one    = 8'd1;
    e      = '0;
    if (eg0) begin
      exp_din = w0d;
      if (w0a != 3'd0) e.load = one << w0a;
    end
    if (eg1) begin
      exp_din = w1d;
      if (w1a != 3'd0) e.load = one << w1a;
    end
    e.d_in = exp_din;
    if (rv) begin
      e.oe_a = one << ra;
      e.oe_b = one << rb;
    end
    e.chk_bus = cb;
    e.bus     = eb;
    exp_q.push_back(W'(e));
  endtask

  task automatic idle();
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'd0, 3'd0, 0, 0, 0, 16'h0);
  endtask

  // Handshake presented, then reset pulled low before the capturing edge.
  task automatic mid_write_reset();
    exp_t e;
    @(negedge clock);
    reset_n   = 1'b1;
    wr0_valid = 1'b1; wr0_addr = 3'd6; wr0_data = 16'h9999;
    wr1_valid = 1'b0; rd_valid = 1'b0;
    #1;
    chk("midrst_ready_before", 32'(wr0_ready), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready_during", 32'(wr0_ready), 32'd0);
    exp_din = 16'h0000;
    e = '0;
    exp_q.push_back(W'(e));
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t        e;
    logic [15:0] bus;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        chk("load", 32'(load), 32'(e.load));
        chk("d_in", 32'(d_in), 32'(e.d_in));
        chk("oe_a", 32'(oe_a), 32'(e.oe_a));
        chk("oe_b", 32'(oe_b), 32'(e.oe_b));
        if (e.chk_bus) begin
          bus = 16'h0000;
          for (int i = 0; i < NREGS; i++) begin
            if (oe_a[i] === 1'b1) bus = bus | regs[i];
          end
          chk("bus_a", 32'(bus), 32'(e.bus));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_din   = 16'h0000;
    reset_n   = 1'b0;
    wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
    rd_valid  = 1'b0; rd_addr_a = '0; rd_addr_b = '0;

    repeat (3) rst_cycle();

    // Contention straight out of reset: grants alternate 0,1,0,1.
    drive(1, 3'd3, 16'hAAAA, 1, 3'd5, 16'h5555, 0, 3'd0, 3'd0, 1, 0, 0, 16'h0);
    drive(1, 3'd3, 16'hAAAA, 1, 3'd5, 16'h5555, 0, 3'd0, 3'd0, 0, 1, 0, 16'h0);
    drive(1, 3'd3, 16'hAAAA, 1, 3'd5, 16'h5555, 0, 3'd0, 3'd0, 1, 0, 0, 16'h0);
    drive(1, 3'd3, 16'hAAAA, 1, 3'd5, 16'h5555, 0, 3'd0, 3'd0, 0, 1, 0, 16'h0);
    idle();

    // Write to register 0: acknowledged, no strobe.
    drive(0, 3'd0, 16'h0, 1, 3'd0, 16'h1234, 0, 3'd0, 3'd0, 0, 1, 0, 16'h0);
    idle();

    // Read with both buses on the same register, one-cycle enables.
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'd2, 3'd2, 0, 0, 0, 16'h0);
    idle();

    // Read-before-write on reg 4, then the new value one cycle later.
    drive(1, 3'd4, 16'h1111, 0, 3'd0, 16'h0, 0, 3'd0, 3'd0, 1, 0, 0, 16'h0);
    idle();
    drive(1, 3'd4, 16'hBEEF, 0, 3'd0, 16'h0, 1, 3'd4, 3'd4, 1, 0, 1, 16'h1111);
    drive(0, 3'd0, 16'h0,    0, 3'd0, 16'h0, 1, 3'd4, 3'd4, 0, 0, 1, 16'hBEEF);

    // Leave the pointer on requester 1, then lone requesters win regardless.
    drive(1, 3'd1, 16'h0101, 1, 3'd2, 16'h0202, 0, 3'd0, 3'd0, 1, 0, 0, 16'h0);
    drive(1, 3'd7, 16'h7777, 0, 3'd0, 16'h0,    0, 3'd0, 3'd0, 1, 0, 0, 16'h0);
    drive(0, 3'd0, 16'h0,    1, 3'd6, 16'h6666, 1, 3'd0, 3'd7, 0, 1, 0, 16'h0);

    // Reset during a pending write: no strobe, pointer back to requester 0.
    mid_write_reset();
    drive(1, 3'd3, 16'h3333, 1, 3'd5, 16'h5555, 0, 3'd0, 3'd0, 1, 0, 0, 16'h0);
    drive(1, 3'd3, 16'h3333, 1, 3'd5, 16'h5555, 0, 3'd0, 3'd0, 0, 1, 0, 16'h0);
    idle();

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clock);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
